// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: turns a decoded command (class, ALU_OP, regs, imm) into a 32-bit word written to instruction memory.
// Latency: one register stage; a command accepted at edge N presents wr_en/wr_data/wr_addr in cycle N+1.
// Backpressure: in_ready = !wr_en | wr_ready, so a stalled write stops intake; 1 word/cycle when wr_ready is held high.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   clr            synchronous clear of address counter, count and err_cnt (pending word untouched)
//   in_valid/ready command handshake
//   cls, alu_op    instruction class (0 R .. 7 JALR) and {funct7[5], funct3}
//   rd, rs1, rs2   register numbers
//   imm            immediate as byte offset/value (LUI uses imm[31:12])
//   wr_en/ready    memory write handshake; wr_addr/wr_data hold steady while stalled
//   err, err_cnt   one-cycle pulse per dropped illegal command, saturating drop counter
//   count          completed writes, saturating at all-ones

module inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [3:0]        alu_op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    // Instruction classes
    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_IMM  = 3'd1;
    localparam logic [2:0] CLS_LUI  = 3'd2;
    localparam logic [2:0] CLS_LW   = 3'd3;
    localparam logic [2:0] CLS_SW   = 3'd4;
    localparam logic [2:0] CLS_BEQ  = 3'd5;
    localparam logic [2:0] CLS_JAL  = 3'd6;
    localparam logic [2:0] CLS_JALR = 3'd7;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [ADDR_W-1:0] addr_q;      // address the next loaded word will take
    logic              err_q;
    logic [7:0]        err_cnt_q;
    logic [ADDR_W:0]   count_q;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] enc_word;
    logic        enc_illegal;

    always_comb begin
        f7          = alu_op[3] ? 7'b0100000 : 7'b0000000;
        f3          = alu_op[2:0];
        enc_word    = 32'h0000_0000;
        enc_illegal = 1'b0;
        case (cls)
            CLS_R: begin
                enc_word    = {f7, rs2, rs1, f3, rd, OPC_OP};
                // Only ADD->SUB and SRL->SRA have an alternate funct7.
                enc_illegal = alu_op[3] && (f3 != 3'b000) && (f3 != 3'b101);
            end
            CLS_IMM: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    // Shifts: shamt in the low immediate bits, funct7 above it.
                    enc_word = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
                end else begin
                    enc_word    = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                    enc_illegal = alu_op[3];
                end
            end
            CLS_LUI: begin
                enc_word = {imm[31:12], rd, OPC_LUI};
            end
            CLS_LW: begin
                enc_word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            end
            CLS_SW: begin
                enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            end
            CLS_BEQ: begin
                enc_word    = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                               imm[4:1], imm[11], OPC_BRANCH};
                // Branch targets are halfword aligned; bit 0 cannot be encoded.
                enc_illegal = imm[0];
            end
            CLS_JAL: begin
                enc_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                enc_illegal = imm[0];
            end
            CLS_JALR: begin
                enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic              accept;
    logic              load;
    logic              drop;
    logic              wr_done;
    logic [ADDR_W-1:0] load_addr;

    assign in_ready = !wr_en_q || wr_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !enc_illegal;
    assign drop     = accept && enc_illegal;
    assign wr_done  = wr_en_q && wr_ready;

    // A word loaded in the same cycle as clr already belongs to the cleared
    // address space, so it takes BASE rather than the stale counter value.
    assign load_addr = clr ? BASE_A : addr_q;

    // ------------------------------------------------------------------
    // Output stage FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_A;
            wr_data_q <= 32'h0000_0000;
            addr_q    <= BASE_A;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            count_q   <= '0;
        end else begin
            err_q <= drop;

            // Address allocation happens at load time, so dropped commands
            // never consume an address and the latched wr_addr never moves.
            if (load) begin
                wr_addr_q <= load_addr;
                wr_data_q <= enc_word;
                addr_q    <= load_addr + ADDR_ONE;
            end else if (clr) begin
                addr_q <= BASE_A;
            end

            // clr wins over any simultaneous increment.
            if (clr) begin
                count_q   <= '0;
                err_cnt_q <= 8'd0;
            end else begin
                if (wr_done && (count_q != '1)) begin
                    count_q <= count_q + CNT_ONE;
                end
                if (drop && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end

            case (state_q)
                ST_EMPTY: begin
                    if (load) begin
                        state_q <= ST_FULL;
                        wr_en_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // In FULL an accept implies wr_ready, so the pending word
                    // always completes when a new one is loaded.
                    if (wr_done && !load) begin
                        state_q <= ST_EMPTY;
                        wr_en_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign count   = count_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder: the inverse of the ID2 class/ALU_OP decode. It accepts one decoded-form command per handshake (instruction class, ALU_OP, register fields, immediate) and assembles the 32-bit instruction word. It writes the word into instruction memory at an auto-incrementing address through a registered write port with backpressure. It sits between the test/program loader and the instruction RAM and lets benches round-trip ID2.

## Interface
- ADDR_W, default 8: word-address width of the instruction memory.
- BASE, default 0: address loaded into the address counter on reset and on `clr`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of the address counter, `count` and `err_cnt`. Does not affect a pending output.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when `in_valid & in_ready`.
- cls  in  3  instruction class: 0 R, 1 IMM, 2 LUI, 3 LW, 4 SW, 5 BEQ, 6 JAL, 7 JALR.
- alu_op  in  4  {funct7[5], funct3}, same meaning as ID2 ALU_OP.
- rd, rs1, rs2  in  5 each  register numbers.
- imm  in  32  immediate as a byte offset/value. LUI uses imm[31:12].
- wr_en  out  1  write valid; holds until `wr_ready`.
- wr_ready  in  1  memory accepts the word.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  instruction word.
- err  out  1  one-cycle pulse: the accepted command was illegal and dropped.
- err_cnt  out  8  illegal commands dropped; saturates at 255.
- count  out  ADDR_W+1  words written; saturates at all-ones.

## Operation
Encoding, with f7 = alu_op[3] ? 0100000 : 0000000 and f3 = alu_op[2:0]:
- R: {f7, rs2, rs1, f3, rd, 0110011}. Illegal if alu_op[3]=1 and f3 is not 000 or 101.
- IMM, f3=001 or 101: {f7, imm[4:0], rs1, f3, rd, 0010011}.
- IMM, other f3: {imm[11:0], rs1, f3, rd, 0010011}. Illegal if alu_op[3]=1.
- LUI: {imm[31:12], rd, 0110111}.
- LW: {imm[11:0], rs1, 010, rd, 0000011}.
- SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
- BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}. Illegal if imm[0]=1.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}. Illegal if imm[0]=1.
- JALR: {imm[11:0], rs1, 000, rd, 1100111}.
- Immediate bits outside the encoded field are ignored and never flagged. For non-R classes alu_op is ignored, except the IMM shift/alt-bit rules above.

Output stage, one register stage:
- EMPTY: `wr_en`=0. A legal accept loads `wr_data` and `wr_addr`, sets `wr_en`=1 and goes to FULL. An illegal accept pulses `err` and stays EMPTY.
- FULL: `wr_en`=1. On `wr_ready`:
  - the address increments by 1 modulo 2^ADDR_W (all-ones wraps to 0);
  - `count` increments;
  - a simultaneous legal accept reloads the stage and it stays FULL; otherwise it goes to EMPTY.
- `in_ready` = !wr_en | wr_ready (combinational). This allows full throughput of 1 word/cycle.
- An illegal command accepted while FULL is consumed and dropped, `err` pulses, and the pending word is unaffected.
- `clr` together with a write completion: the clear wins. The address becomes BASE and `count`=0. An already-latched `wr_addr` is not modified.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=BASE, `wr_data`=0, `err`=0, `err_cnt`=0, `count`=0, state EMPTY. `in_ready`=1 one cycle after reset deasserts.
- Reset mid-operation discards the pending word with no write.
- Latency: command accepted at edge N gives `wr_en`/`wr_data` valid after edge N, i.e. in cycle N+1.
- `wr_data` and `wr_addr` are stable while `wr_en`=1 and `wr_ready`=0.
- `err` is asserted for exactly the cycle after the illegal accept. `err_cnt` updates on the same edge.
- Next `wr_addr` = previous `wr_addr` + 1 after each completed write, with wrap-around. Dropped commands do not consume an address.

## Test plan
- After reset, with `wr_ready`=1, send four commands back to back:
  - add x3,x1,x2
  - sub x3,x1,x2
  - addi x5,x0,-1
  - lui x1,0x12345
  
  Required: data 0x002081B3, 0x402081B3, 0xFFF00293, 0x123450B7 at addresses 0,1,2,3 on consecutive cycles; `count`=4.
- sw x2,8(x1) -> 0x0020A423. jal x1,8 -> 0x008000EF. srai x4,x1,3 -> 0x4030D213. Feed each encoded word into ID2 and check IS_* and ALU_OP match the cls and alu_op sent.
- Backpressure: hold `wr_ready`=0 for 5 cycles with `in_valid`=1. Required: `in_ready`=0; `wr_data` and `wr_addr` constant; no lost or duplicated word after release.
- Illegal commands: BEQ with imm=3, then R with alu_op=1001. Required: two `err` pulses, `err_cnt`=2, no write, and the next legal word lands at the unchanged address.
- Wrap: ADDR_W=2. Write 5 words. Required: addresses 0,1,2,3,0; `count`=5.
- `clr` and `rst` asserted while FULL and stalled:
  - `clr`: the pending word completes at its latched address, and the next word goes to BASE.
  - `rst`: `wr_en` drops and no write occurs.
